data_memory_arbiter: RTL and testbench
======================================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data and address width.
REQ-002 SHALL have parameter LOCK_MAX, default 16: max consecutive locked cycles before forced release.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports m0_req / m1_req, input, 1: access request, masters 0 (CPU) and 1 (DMA).
REQ-006 SHALL have ports m0_we / m1_we, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have ports m0_lock / m1_lock, input, 1: request atomic ownership, e.g. for read-modify-write.
REQ-008 SHALL have ports m0_addr / m1_addr and m0_wdata / m1_wdata, input, DATA_WIDTH: access address and write data.
REQ-009 SHALL have ports m0_gnt / m1_gnt, output, 1: combinational grant; access completes at the next clk edge.
REQ-010 SHALL have ports m0_rvalid / m1_rvalid, output, 1: registered one-cycle read-response pulse.
REQ-011 SHALL have ports m0_rdata / m1_rdata, output, DATA_WIDTH: registered read data.
REQ-012 SHALL have ports mem_addr / mem_wdata, output, DATA_WIDTH, and mem_write / mem_read, output, 1: drive the data memory.
REQ-013 SHALL have port mem_rdata, input, DATA_WIDTH: combinational memory read data.

Function
- REQ-014 SHALL grant at most one master per cycle; gnt = selected & req.
- REQ-015 SHALL, in UNLOCKED with both requests asserted, grant the master not granted last (round-robin via last_gnt register).
- REQ-016 SHALL, in UNLOCKED with one request asserted, grant that master regardless of last_gnt.
- REQ-017 SHALL route the granted master's addr and wdata to mem_addr and mem_wdata.
  - mem_write = gnt & we.
  - mem_read = gnt & ~we.
- REQ-018 SHALL, with no grant, drive mem_write = 0, mem_read = 0, mem_addr = 0 and mem_wdata = 0.
- REQ-019 SHALL, on a granted read, capture mem_rdata into that master's rdata at the edge, then assert rvalid for exactly the following cycle (1-cycle latency).
- REQ-020 SHALL hold rdata until that master's next granted read; writes do not pulse rvalid.
- REQ-021 SHALL use FSM states UNLOCKED, LOCKED_M0 and LOCKED_M1.
- REQ-022 SHALL transition UNLOCKED -> LOCKED_Mx at an edge where master x is granted with lock = 1.
- REQ-023 SHALL, in LOCKED_Mx, grant only master x; the other master's gnt = 0 even if requesting.
- REQ-024 SHALL transition LOCKED_Mx -> UNLOCKED at the first edge where mx_lock = 0, whether or not mx_req is asserted.
- REQ-025 SHALL count cycles in LOCKED_Mx; when the count reaches LOCK_MAX it SHALL force a return to UNLOCKED and set last_gnt = x so the other master wins next.
  - The count resets on entry to a locked state.
  - After forced release, master x SHALL NOT re-enter a lock until it deasserts lock for one edge.
- REQ-026 SHALL update last_gnt on every granted edge.
- REQ-027 SHALL NOT lose a request when simultaneous requests arrive with a lock; requests stay pending, with no internal queueing, until granted.

Reset
- REQ-028 SHALL, on reset = 1 (asynchronous):
  - FSM = UNLOCKED.
  - last_gnt = 1, so m0 wins first contention.
  - lock counter = 0.
  - rvalid = 0, rdata = 0.
  - The lock-rearm flags are cleared.
- REQ-029 SHALL cancel any in-flight read response on reset mid-operation: no rvalid after reset deassertion.
- REQ-030 SHALL drive all combinational memory outputs to 0 while reset = 1.

Structure
- REQ-031 SHALL place the state encoding (UNLOCKED = 2'd0, LOCKED_M0 = 2'd1, LOCKED_M1 = 2'd2) and the LOCK_MAX default in a shared package / include with the MIPS definitions.
- REQ-032 SHALL instantiate one sub-module, rr_pick2: a 2-requester round-robin pick from req[1:0] and last_gnt.
- REQ-033 SHALL NOT instantiate the memory; the memory is connected at the top level.

Verification
- REQ-034 SHALL cover contention: m0 and m1 both read continuously from 0x10 and 0x20 for 4 cycles -> grants alternate m0, m1, m0, m1; each rvalid follows its grant by 1 cycle with the correct data.
- REQ-035 SHALL cover a single write: m1 writes 0xDEADBEEF to 0x08, then m0 reads 0x08 -> mem_write pulses once; m0_rdata = 0xDEADBEEF with m0_rvalid 1 cycle after the grant.
- REQ-036 SHALL cover lock: m0 holds lock for 3 accesses while m1 requests -> m1_gnt = 0 for those 3 cycles; m1 is granted on the edge after m0_lock falls.
- REQ-037 SHALL cover lock timeout: m1 holds lock with req high for 20 cycles while m0 requests -> forced release after 16 locked cycles; m0 is granted next; m1 is not relocked until it drops lock.
- REQ-038 SHALL cover reset mid-read: assert reset in the cycle after an m0 read grant -> m0_rvalid = 0 and m0_rdata = 0; the first post-reset contention is won by m0.
- REQ-039 SHALL cover idle: no requests -> mem_read = mem_write = 0 and all gnt/rvalid = 0 every cycle.

Source files
------------

// File: rtl/data_memory_arbiter_pkg.sv
// data_memory_arbiter_pkg: shared lock-FSM encoding and MIPS data-memory defaults
package data_memory_arbiter_pkg;
   localparam int MIPS_WORD_BITS = 32;
   localparam int LOCK_MAX_DEF = 16;
   typedef enum logic [1:0] {
      UNLOCKED  = 2'd0,
      LOCKED_M0 = 2'd1,
      LOCKED_M1 = 2'd2
   } lock_state_e;
endpackage

// File: rtl/data_memory_arbiter_rr_pick2.sv
// rr_pick2: two-requester round-robin pick, favouring the master not granted last
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic [1:0] gnt
);
   always_comb gnt = &req ? (last_gnt ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: CPU/DMA round-robin data-memory arbiter with bounded atomic locking
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = MIPS_WORD_BITS,
   parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic                  m0_lock,
   input  logic [DATA_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic                  m1_lock,
   input  logic [DATA_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_write,
   output logic                  mem_read,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   localparam int CW = $clog2(LOCK_MAX + 1);
   lock_state_e           state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  last_q, last_d;
   logic [1:0]            block_q, block_d;
   logic [1:0]            rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [1:0]            req, we, lock, rr_gnt, gnt;
   logic                  own;
   assign req  = {m1_req, m0_req};
   assign we   = {m1_we, m0_we};
   assign lock = {m1_lock, m0_lock};
   rr_pick2 u_pick (
      .req      (req),
      .last_gnt (last_q),
      .gnt      (rr_gnt)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q  <= UNLOCKED;
         cnt_q    <= '0;
         last_q   <= 1'b1;
         block_q  <= '0;
         rvalid_q <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         block_q  <= block_d;
         rvalid_q <= rvalid_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   // block_q keeps a force-released master from relocking until it drops lock for an edge
   always_comb begin
      own     = state_q == LOCKED_M1;
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = |gnt ? gnt[1] : last_q;
      block_d = block_q & lock;
      if (state_q == UNLOCKED) begin
         if (|(gnt & lock & ~block_q)) begin
            state_d = gnt[1] ? LOCKED_M1 : LOCKED_M0;
            cnt_d   = '0;
         end
      end else if (!lock[own])
         state_d = UNLOCKED;
      else if (cnt_q == CW'(LOCK_MAX - 1)) begin
         state_d      = UNLOCKED;
         last_d       = own;
         block_d[own] = 1'b1;
      end else
         cnt_d = cnt_q + CW'(1);
   end
   always_comb begin
      gnt       = reset ? 2'b00 : state_q == LOCKED_M0 ? {1'b0, m0_req} :
                  state_q == LOCKED_M1 ? {m1_req, 1'b0} : rr_gnt;
      mem_addr  = gnt[0] ? m0_addr : gnt[1] ? m1_addr : '0;
      mem_wdata = gnt[0] ? m0_wdata : gnt[1] ? m1_wdata : '0;
      mem_write = |(gnt & we);
      mem_read  = |(gnt & ~we);
      rvalid_d  = gnt & ~we;
      rdata0_d  = rvalid_d[0] ? mem_rdata : rdata0_q;
      rdata1_d  = rvalid_d[1] ? mem_rdata : rdata1_q;
   end
   assign m0_gnt    = gnt[0];
   assign m1_gnt    = gnt[1];
   assign m0_rvalid = rvalid_q[0];
   assign m1_rvalid = rvalid_q[1];
   assign m0_rdata  = rdata0_q;
   assign m1_rdata  = rdata1_q;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed vector table plus lock-timeout and reset-mid-read sequences
module tb_data_memory_arbiter;
   typedef struct {
      logic [2:0]  m0, m1;
      logic [31:0] a0, d0, a1, d1;
      logic [3:0]  g;
      logic [31:0] ma, md;
      logic [1:0]  v;
      logic [31:0] rd0, rd1;
   } vec_t;
   logic        clk, reset, mem_clr;
   logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_write, mem_read;
   logic [31:0] mem [0:255];
   logic [255:0] wr;
   logic        e0, e1, l1;
   int          n_cmp = 0, n_err = 0;
   vec_t        tbl[$];
   data_memory_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
      .mem_rdata(mem_rdata)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   // unwritten locations read back as 0x5A000000 | addr
   always @(posedge clk)
      if (mem_clr) wr <= '0;
      else if (mem_write) begin
         mem[mem_addr[7:0]] <= mem_wdata;
         wr[mem_addr[7:0]]  <= 1'b1;
      end
   assign mem_rdata = wr[mem_addr[7:0]] ? mem[mem_addr[7:0]] : (32'h5A00_0000 | mem_addr);
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask
   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask
   task automatic drive(input logic [2:0] m0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic [2:0] m1, input logic [31:0] a1, input logic [31:0] d1);
      {m0_req, m0_we, m0_lock} = m0;
      {m1_req, m1_we, m1_lock} = m1;
      m0_addr = a0; m0_wdata = d0; m1_addr = a1; m1_wdata = d1;
   endtask
   function automatic vec_t row(input logic [2:0] m0, input logic [31:0] a0, input logic [31:0] d0,
                                input logic [2:0] m1, input logic [31:0] a1, input logic [31:0] d1,
                                input logic [3:0] g, input logic [31:0] ma, input logic [31:0] md,
                                input logic [1:0] v, input logic [31:0] rd0, input logic [31:0] rd1);
      vec_t r;
      r.m0 = m0; r.a0 = a0; r.d0 = d0; r.m1 = m1; r.a1 = a1; r.d1 = d1;
      r.g = g; r.ma = ma; r.md = md; r.v = v; r.rd0 = rd0; r.rd1 = rd1;
      return r;
   endfunction
   initial begin
      // fields: m0 {req,we,lock}, a0, d0, m1 {req,we,lock}, a1, d1, g {g0,g1,mw,mr}, ma, md, v {v0,v1}, rd0, rd1
      tbl.push_back(row(3'b000, 32'h33, 32'h1234, 3'b000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0));
      tbl.push_back(row(3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0));
      tbl.push_back(row(3'b100, 32'h10, 32'h0, 3'b100, 32'h20, 32'h0, 4'b1001, 32'h10, 32'h0, 2'b00, 32'h0, 32'h0));
      tbl.push_back(row(3'b100, 32'h10, 32'h0, 3'b100, 32'h20, 32'h0, 4'b0101, 32'h20, 32'h0, 2'b10, 32'h5A000010, 32'h0));
      tbl.push_back(row(3'b100, 32'h10, 32'h0, 3'b100, 32'h20, 32'h0, 4'b1001, 32'h10, 32'h0, 2'b01, 32'h5A000010, 32'h5A000020));
      tbl.push_back(row(3'b100, 32'h10, 32'h0, 3'b100, 32'h20, 32'h0, 4'b0101, 32'h20, 32'h0, 2'b10, 32'h5A000010, 32'h5A000020));
      tbl.push_back(row(3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 2'b01, 32'h5A000010, 32'h5A000020));
      tbl.push_back(row(3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 2'b00, 32'h5A000010, 32'h5A000020));
      tbl.push_back(row(3'b000, 32'h0, 32'h0, 3'b110, 32'h08, 32'hDEADBEEF, 4'b0110, 32'h08, 32'hDEADBEEF, 2'b00, 32'h5A000010, 32'h5A000020));
      tbl.push_back(row(3'b100, 32'h08, 32'h0, 3'b000, 32'h0, 32'h0, 4'b1001, 32'h08, 32'h0, 2'b00, 32'h5A000010, 32'h5A000020));
      tbl.push_back(row(3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 2'b10, 32'hDEADBEEF, 32'h5A000020));
      tbl.push_back(row(3'b000, 32'h0, 32'h0, 3'b100, 32'h20, 32'h0, 4'b0101, 32'h20, 32'h0, 2'b00, 32'hDEADBEEF, 32'h5A000020));
      tbl.push_back(row(3'b101, 32'h10, 32'h0, 3'b100, 32'h20, 32'h0, 4'b1001, 32'h10, 32'h0, 2'b01, 32'hDEADBEEF, 32'h5A000020));
      tbl.push_back(row(3'b111, 32'h10, 32'h0BADF00D, 3'b100, 32'h20, 32'h0, 4'b1010, 32'h10, 32'h0BADF00D, 2'b10, 32'h5A000010, 32'h5A000020));
      tbl.push_back(row(3'b101, 32'h10, 32'h0, 3'b100, 32'h20, 32'h0, 4'b1001, 32'h10, 32'h0, 2'b00, 32'h5A000010, 32'h5A000020));
      tbl.push_back(row(3'b000, 32'h0, 32'h0, 3'b100, 32'h20, 32'h0, 4'b0000, 32'h0, 32'h0, 2'b10, 32'h0BADF00D, 32'h5A000020));
      tbl.push_back(row(3'b000, 32'h0, 32'h0, 3'b100, 32'h20, 32'h0, 4'b0101, 32'h20, 32'h0, 2'b00, 32'h0BADF00D, 32'h5A000020));
      tbl.push_back(row(3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 2'b01, 32'h0BADF00D, 32'h5A000020));
      reset = 1'b1;
      mem_clr = 1'b1;
      drive(3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0);
      @(posedge clk); #1;
      mem_clr = 1'b0;
      drive(3'b100, 32'h10, 32'h0, 3'b100, 32'h20, 32'h0);
      @(negedge clk);
      chk1("rst_m0_gnt", m0_gnt, 1'b0);
      chk1("rst_m1_gnt", m1_gnt, 1'b0);
      chk1("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
      chk("rst_m0_rdata", m0_rdata, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].m0, tbl[i].a0, tbl[i].d0, tbl[i].m1, tbl[i].a1, tbl[i].d1);
         @(negedge clk);
         chk1($sformatf("r%0d_m0_gnt", i), m0_gnt, tbl[i].g[3]);
         chk1($sformatf("r%0d_m1_gnt", i), m1_gnt, tbl[i].g[2]);
         chk1($sformatf("r%0d_mem_write", i), mem_write, tbl[i].g[1]);
         chk1($sformatf("r%0d_mem_read", i), mem_read, tbl[i].g[0]);
         chk($sformatf("r%0d_mem_addr", i), mem_addr, tbl[i].ma);
         chk($sformatf("r%0d_mem_wdata", i), mem_wdata, tbl[i].md);
         chk1($sformatf("r%0d_m0_rvalid", i), m0_rvalid, tbl[i].v[1]);
         chk1($sformatf("r%0d_m1_rvalid", i), m1_rvalid, tbl[i].v[0]);
         chk($sformatf("r%0d_m0_rdata", i), m0_rdata, tbl[i].rd0);
         chk($sformatf("r%0d_m1_rdata", i), m1_rdata, tbl[i].rd1);
         @(posedge clk); #1;
      end
      // m0 alone first so m1 wins the contention that opens the lock
      drive(3'b100, 32'h10, 32'h0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      chk1("to_pre_m0_gnt", m0_gnt, 1'b1);
      @(posedge clk); #1;
      for (int c = 0; c < 24; c++) begin
         l1 = c != 20;
         drive(3'b100, 32'h10, 32'h0, {1'b1, 1'b0, l1}, 32'h20, 32'h0);
         @(negedge clk);
         e0 = c == 17 || c == 19 || c == 21;
         e1 = c <= 16 || c == 18 || c == 20 || c >= 22;
         chk1($sformatf("to%0d_m0_gnt", c), m0_gnt, e0);
         chk1($sformatf("to%0d_m1_gnt", c), m1_gnt, e1);
         @(posedge clk); #1;
      end
      drive(3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      chk1("idle_mem_read", mem_read, 1'b0);
      chk1("idle_mem_write", mem_write, 1'b0);
      @(posedge clk); #1;
      drive(3'b100, 32'h10, 32'h0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      chk1("mr_m0_gnt", m0_gnt, 1'b1);
      @(posedge clk); #1;
      chk1("mr_inflight_rvalid", m0_rvalid, 1'b1);
      reset = 1'b1;
      #1;
      chk1("mr_rst_rvalid", m0_rvalid, 1'b0);
      chk("mr_rst_rdata", m0_rdata, 32'h0);
      chk("mr_rst_m1_rdata", m1_rdata, 32'h0);
      chk1("mr_rst_gnt", m0_gnt, 1'b0);
      chk1("mr_rst_mem_read", mem_read, 1'b0);
      chk("mr_rst_mem_addr", mem_addr, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      drive(3'b100, 32'h10, 32'h0, 3'b100, 32'h20, 32'h0);
      @(negedge clk);
      chk1("post_rst_rvalid", m0_rvalid, 1'b0);
      chk1("post_rst_m0_gnt", m0_gnt, 1'b1);
      chk1("post_rst_m1_gnt", m1_gnt, 1'b0);
      @(posedge clk); #1;
      drive(3'b000, 32'h0, 32'h0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      chk1("post_rst_rvalid2", m0_rvalid, 1'b1);
      chk("post_rst_rdata", m0_rdata, 32'h0BADF00D);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
